// File: rtl/matmul_pkg.sv
// matmul_pkg
//   Constants and the FSM state type shared by the matrix-multiply sequencer
//   and its index generator. Memory layout: one dimension word, then the
//   row-major A, B and C matrices at fixed bases.
package matmul_pkg;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;
    localparam int MAX_N  = 32;

    // Wide enough for N (1..32) and for indices 0..31.
    localparam int CNT_W  = 6;
    localparam logic [CNT_W-1:0] MAX_N_W = CNT_W'(MAX_N);

    localparam logic [ADDR_W-1:0] N_ADDR = 12'h000;
    localparam logic [ADDR_W-1:0] A_BASE = 12'h001;
    localparam logic [ADDR_W-1:0] B_BASE = 12'h401;
    localparam logic [ADDR_W-1:0] C_BASE = 12'h801;

    typedef enum logic [3:0] {
        IDLE,
        RD_N,
        WAIT_N,
        RD_A,
        RD_B,
        CAP_B,
        SEND,
        WAIT_ACC,
        WR_C,
        DONE
    } state_e;

endpackage

// File: rtl/matmul_idx_gen.sv
// matmul_idx_gen
//   Owns the i/j/k loop counters and the A-row, B and C pointers for one
//   matrix product. All pointers move by addition only (no multiplier);
//   address arithmetic wraps modulo 2^ADDR_W.
// Ports:
//   clk, rst        clock, asynchronous active-high reset (clears everything)
//   init            load i=j=k=0 and the base pointers
//   step_k          advance k within the current C element (B moves down a row)
//   step_j          finish the current C element (advance j, or i on row end)
//   n               latched matrix dimension
//   a_addr/b_addr/c_addr  addresses of A[i][k], B[k][j], C[i][j]
//   first_k, last_k, last_j, last_i  loop position flags
module matmul_idx_gen
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              step_k,
    input  logic              step_j,
    input  logic [CNT_W-1:0]  n,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic [ADDR_W-1:0] c_addr,
    output logic              first_k,
    output logic              last_k,
    output logic              last_j,
    output logic              last_i
);

    logic [CNT_W-1:0]  i_q, i_d, j_q, j_d, k_q, k_d;
    logic [ADDR_W-1:0] a_row_q, a_row_d, b_ptr_q, b_ptr_d, c_ptr_q, c_ptr_d;
    logic [CNT_W-1:0]  n_m1;
    logic [ADDR_W-1:0] n_ext;

    assign n_m1  = n - CNT_W'(1);
    assign n_ext = ADDR_W'(n);

    assign a_addr  = a_row_q + ADDR_W'(k_q);
    assign b_addr  = b_ptr_q;
    assign c_addr  = c_ptr_q;
    assign first_k = (k_q == '0);
    assign last_k  = (k_q == n_m1);
    assign last_j  = (j_q == n_m1);
    assign last_i  = (i_q == n_m1);

    always_comb begin
        i_d     = i_q;
        j_d     = j_q;
        k_d     = k_q;
        a_row_d = a_row_q;
        b_ptr_d = b_ptr_q;
        c_ptr_d = c_ptr_q;
        if (init) begin
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            a_row_d = A_BASE;
            b_ptr_d = B_BASE;
            c_ptr_d = C_BASE;
        end else if (step_k) begin
            // Next k: B pointer moves down one row of B.
            k_d     = k_q + CNT_W'(1);
            b_ptr_d = b_ptr_q + n_ext;
        end else if (step_j) begin
            k_d     = '0;
            c_ptr_d = c_ptr_q + ADDR_W'(1);
            if (!last_j) begin
                // Next column: B restarts at the top of column j+1.
                j_d     = j_q + CNT_W'(1);
                b_ptr_d = B_BASE + ADDR_W'(j_q) + ADDR_W'(1);
            end else if (!last_i) begin
                i_d     = i_q + CNT_W'(1);
                j_d     = '0;
                a_row_d = a_row_q + n_ext;
                b_ptr_d = B_BASE;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_q     <= '0;
            j_q     <= '0;
            k_q     <= '0;
            a_row_q <= '0;
            b_ptr_q <= '0;
            c_ptr_q <= '0;
        end else begin
            i_q     <= i_d;
            j_q     <= j_d;
            k_q     <= k_d;
            a_row_q <= a_row_d;
            b_ptr_q <= b_ptr_d;
            c_ptr_q <= c_ptr_d;
        end
    end

endmodule

// File: rtl/matmul_sequencer.sv
// matmul_sequencer
//   Control FSM for one NxN product C = A x B held in the shared matrix
//   memory. Reads N, fetches A[i][k]/B[k][j] pairs, streams them to an
//   external MAC, and writes each returned C[i][j] back to memory.
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   start                   one-cycle pulse, accepted only in IDLE
//   busy                    run in progress (accepted start until DONE)
//   result_ready, error     sticky status, cleared by the next accepted start
//   mem_addr/mem_rd_en/mem_wr_en/mem_wdata/mem_rdata
//                           memory port; read data returns one cycle after rd_en
//   op_a/op_b/op_valid/op_ready/op_first/op_last
//                           operand stream to the MAC
//   acc_valid/acc_data      accumulated C element back from the MAC
//   state_dbg               current FSM state
//
// Operand handshake: a pair transfers on a rising edge where op_valid and
// op_ready are both high; while op_valid is high and op_ready low, op_a,
// op_b, op_first and op_last are held unchanged.
module matmul_sequencer
    import matmul_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              result_ready,
    output logic              error,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              op_valid,
    input  logic              op_ready,
    output logic              op_first,
    output logic              op_last,
    input  logic              acc_valid,
    input  logic [DATA_W-1:0] acc_data,
    output state_e            state_dbg
);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  n_q, n_d;
    logic [DATA_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, acc_q, acc_d;
    logic              result_ready_q, result_ready_d;
    logic              error_q, error_d;

    logic              idx_init, idx_step_k, idx_step_j;
    logic [ADDR_W-1:0] a_addr, b_addr, c_addr;
    logic              first_k, last_k, last_j, last_i;
    logic [CNT_W-1:0]  n_rd;

    // Only the low bits of the dimension word are meaningful.
    assign n_rd = mem_rdata[CNT_W-1:0];

    matmul_idx_gen u_idx (
        .clk     (clk),
        .rst     (reset),
        .init    (idx_init),
        .step_k  (idx_step_k),
        .step_j  (idx_step_j),
        .n       (n_q),
        .a_addr  (a_addr),
        .b_addr  (b_addr),
        .c_addr  (c_addr),
        .first_k (first_k),
        .last_k  (last_k),
        .last_j  (last_j),
        .last_i  (last_i)
    );

    always_comb begin
        state_d        = state_q;
        n_d            = n_q;
        op_a_d         = op_a_q;
        op_b_d         = op_b_q;
        acc_d          = acc_q;
        result_ready_d = result_ready_q;
        error_d        = error_q;
        mem_addr       = '0;
        mem_rd_en      = 1'b0;
        mem_wr_en      = 1'b0;
        mem_wdata      = '0;
        op_valid       = 1'b0;
        op_first       = 1'b0;
        op_last        = 1'b0;
        idx_init       = 1'b0;
        idx_step_k     = 1'b0;
        idx_step_j     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    result_ready_d = 1'b0;
                    error_d        = 1'b0;
                    state_d        = RD_N;
                end
            end
            RD_N: begin
                mem_addr  = N_ADDR;
                mem_rd_en = 1'b1;
                state_d   = WAIT_N;
            end
            WAIT_N: begin
                n_d = n_rd;
                if (n_rd == '0 || n_rd > MAX_N_W) begin
                    error_d = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_init = 1'b1;
                    state_d  = RD_A;
                end
            end
            RD_A: begin
                mem_addr  = a_addr;
                mem_rd_en = 1'b1;
                state_d   = RD_B;
            end
            RD_B: begin
                // A word from the RD_A read arrives now; B read overlaps it.
                op_a_d    = mem_rdata;
                mem_addr  = b_addr;
                mem_rd_en = 1'b1;
                state_d   = CAP_B;
            end
            CAP_B: begin
                op_b_d  = mem_rdata;
                state_d = SEND;
            end
            SEND: begin
                op_valid = 1'b1;
                op_first = first_k;
                op_last  = last_k;
                if (op_ready) begin
                    if (!last_k) begin
                        idx_step_k = 1'b1;
                        state_d    = RD_A;
                    end else begin
                        state_d = WAIT_ACC;
                    end
                end
            end
            WAIT_ACC: begin
                if (acc_valid) begin
                    acc_d   = acc_data;
                    state_d = WR_C;
                end
            end
            WR_C: begin
                mem_addr   = c_addr;
                mem_wr_en  = 1'b1;
                mem_wdata  = acc_q;
                idx_step_j = 1'b1;
                state_d    = (last_j && last_i) ? DONE : RD_A;
            end
            DONE: begin
                result_ready_d = ~error_q;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            n_q            <= '0;
            op_a_q         <= '0;
            op_b_q         <= '0;
            acc_q          <= '0;
            result_ready_q <= 1'b0;
            error_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            n_q            <= n_d;
            op_a_q         <= op_a_d;
            op_b_q         <= op_b_d;
            acc_q          <= acc_d;
            result_ready_q <= result_ready_d;
            error_q        <= error_d;
        end
    end

    assign busy         = (state_q != IDLE) && (state_q != DONE);
    assign result_ready = result_ready_q;
    assign error        = error_q;
    assign op_a         = op_a_q;
    assign op_b         = op_b_q;
    assign state_dbg    = state_q;

endmodule

// File: tb/tb_matmul_sequencer.sv
// tb_matmul_sequencer
//   Bench for matmul_sequencer: behavioural memory, a multiply-accumulate
//   responder, a reference matrix product computed with plain arithmetic,
//   and a negedge monitor that scores operand pairs and C writes against
//   expected queues.
module tb_matmul_sequencer;
    import matmul_pkg::*;

    // ---------------- clock / DUT signals ----------------
    logic        clk = 1'b0;
    logic        reset, start;
    logic        busy, result_ready, error;
    logic [11:0] mem_addr;
    logic        mem_rd_en, mem_wr_en;
    logic [31:0] mem_wdata, mem_rdata;
    logic [31:0] op_a, op_b;
    logic        op_valid, op_ready, op_first, op_last;
    logic        acc_valid;
    logic [31:0] acc_data;
    state_e      state_dbg;

    always #5 clk = ~clk;

    matmul_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .result_ready (result_ready),
        .error        (error),
        .mem_addr     (mem_addr),
        .mem_rd_en    (mem_rd_en),
        .mem_wr_en    (mem_wr_en),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_first     (op_first),
        .op_last      (op_last),
        .acc_valid    (acc_valid),
        .acc_data     (acc_data),
        .state_dbg    (state_dbg)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    logic [31:0] mem [0:4095];
    logic        tb_we;
    logic [11:0] tb_waddr;
    logic [31:0] tb_wdata;

    always @(posedge clk) begin
        if (tb_we) mem[tb_waddr] <= tb_wdata;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem_rd_en ? mem[mem_addr] : 32'hDEAD_BEEF;
    end

    // ---------------- MAC responder ----------------
    int          mac_lat_min, mac_lat_max, mac_wait;
    logic        mac_pend, noise_en;
    logic [31:0] mac_sum;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mac_sum   <= '0;
            mac_pend  <= 1'b0;
            mac_wait  <= 0;
            acc_valid <= 1'b0;
            acc_data  <= '0;
        end else begin
            acc_valid <= 1'b0;
            if (op_valid && op_ready) begin
                mac_sum <= (op_first ? 32'd0 : mac_sum) + op_a * op_b;
                if (op_last) begin
                    mac_pend <= 1'b1;
                    mac_wait <= int'($urandom_range(mac_lat_max, mac_lat_min));
                end
            end else if (mac_pend) begin
                if (mac_wait == 0) begin
                    acc_valid <= 1'b1;
                    acc_data  <= mac_sum;
                    mac_pend  <= 1'b0;
                end else begin
                    mac_wait <= mac_wait - 1;
                end
            end else if (noise_en && $urandom_range(3, 0) == 0) begin
                // Stray pulse while the sequencer is not waiting for a sum.
                acc_valid <= 1'b1;
                acc_data  <= 32'hBAD0_BAD0;
            end
        end
    end

    // ---------------- scoreboard queues and monitor ----------------
    logic [65:0] exp_pair_q[$];   // {a, b, first, last}
    logic [43:0] exp_wr_q[$];     // {addr, data}
    int          pair_cnt, wr_cnt, pair_err, wr_err, proto_err, stall_err;
    int          ready_mode;      // 0: always ready, 1: 3-cycle stall per pair, 2: random
    int          stall_cnt;
    logic        stalled_prev;
    logic [66:0] stalled_val;

    always @(negedge clk) begin
        case (ready_mode)
            0:       op_ready = 1'b1;
            1:       op_ready = (stall_cnt >= 3);
            default: op_ready = 1'($urandom_range(1, 0));
        endcase
        if (reset) begin
            stall_cnt    = 0;
            stalled_prev = 1'b0;
        end else begin
            if (stalled_prev && {op_valid, op_a, op_b, op_first, op_last} !== stalled_val)
                stall_err++;
            stalled_prev = op_valid && !op_ready;
            stalled_val  = {op_valid, op_a, op_b, op_first, op_last};
            if (op_valid && op_ready) begin
                stall_cnt = 0;
                pair_cnt++;
                if (exp_pair_q.size() == 0) pair_err++;
                else if (exp_pair_q.pop_front() !== {op_a, op_b, op_first, op_last}) pair_err++;
            end else if (op_valid) begin
                stall_cnt++;
            end
            if (mem_wr_en) begin
                wr_cnt++;
                if (exp_wr_q.size() == 0) wr_err++;
                else if (exp_wr_q.pop_front() !== {mem_addr, mem_wdata}) wr_err++;
            end
            if (mem_rd_en && mem_wr_en) proto_err++;
            if (!mem_rd_en && !mem_wr_en && mem_addr != 12'h000) proto_err++;
        end
    end

    // ---------------- reference model and driver tasks ----------------
    logic [31:0] ma [0:31][0:31];
    logic [31:0] mb [0:31][0:31];
    logic [31:0] mc [0:31][0:31];

    function automatic logic [31:0] sentinel(input int idx);
        return 32'hC0DE_0000 | 32'(idx);
    endfunction

    task automatic poke(input logic [11:0] a, input logic [31:0] d);
        tb_we    = 1'b1;
        tb_waddr = a;
        tb_wdata = d;
        @(negedge clk);
        tb_we    = 1'b0;
    endtask

    task automatic gen_random(input int n, input bit full);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < n; k++) begin
                ma[i][k] = full ? $urandom : $urandom_range(255, 0);
                mb[i][k] = full ? $urandom : $urandom_range(255, 0);
            end
    endtask

    // Compute C, build the expected pair/write streams, and load memory.
    task automatic load_and_model(input int n, input logic [31:0] nword, input bit fill_c);
        logic [31:0] s;
        pair_cnt = 0; wr_cnt = 0; pair_err = 0; wr_err = 0; proto_err = 0; stall_err = 0;
        exp_pair_q.delete();
        exp_wr_q.delete();
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++) begin
                s = 32'd0;
                for (int k = 0; k < n; k++) begin
                    s = s + ma[i][k] * mb[k][j];
                    exp_pair_q.push_back({ma[i][k], mb[k][j], k == 0, k == n - 1});
                end
                mc[i][j] = s;
                exp_wr_q.push_back({12'(C_BASE + 12'(i * n + j)), s});
            end
        poke(N_ADDR, nword);
        for (int i = 0; i < n; i++)
            for (int k = 0; k < n; k++) begin
                poke(12'(A_BASE + 12'(i * n + k)), ma[i][k]);
                poke(12'(B_BASE + 12'(i * n + k)), mb[i][k]);
                if (fill_c) poke(12'(C_BASE + 12'(i * n + k)), sentinel(i * n + k));
            end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int c = 0;
        while (!(result_ready || error) && c < budget) begin
            @(negedge clk);
            c++;
        end
        check({tag, "_done_in_budget"}, 64'(result_ready || error), 1);
        @(negedge clk);
    endtask

    task automatic check_run(input string tag, input int n);
        check({tag, "_result_ready"}, result_ready, 1);
        check({tag, "_error"}, error, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_pairs"}, pair_cnt, n * n * n);
        check({tag, "_writes"}, wr_cnt, n * n);
        check({tag, "_pair_mism"}, pair_err, 0);
        check({tag, "_write_mism"}, wr_err, 0);
        check({tag, "_strobe_rules"}, proto_err, 0);
        check({tag, "_stall_stable"}, stall_err, 0);
        check({tag, "_leftover"}, exp_pair_q.size() + exp_wr_q.size(), 0);
        for (int i = 0; i < n; i++)
            for (int j = 0; j < n; j++)
                check($sformatf("%s_c%0d_%0d", tag, i, j),
                      mem[12'(C_BASE + 12'(i * n + j))], mc[i][j]);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_ctl"}, {busy, result_ready, error, mem_rd_en, mem_wr_en,
                              op_valid, op_first, op_last}, 0);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_wdata"}, mem_wdata, 0);
        check({tag, "_op_a"}, op_a, 0);
        check({tag, "_op_b"}, op_b, 0);
        check({tag, "_state"}, state_dbg, IDLE);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    logic [31:0] err_words [3] = '{32'd0, 32'd33, 32'h0000_0040};
    int cnt;

    initial begin
        reset = 1'b1; start = 1'b0; tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
        ready_mode = 0; noise_en = 1'b0; mac_lat_min = 0; mac_lat_max = 0;
        op_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_busy", busy, 0);

        // N=1: single pair, first and last together.
        ma[0][0] = 32'd3; mb[0][0] = 32'd5;
        load_and_model(1, 32'd1, 1);
        do_start();
        check("t1_busy_after_start", busy, 1);
        wait_done("t1", 2000);
        check_run("t1", 1);
        check("t1_c_literal", mem[12'h801], 32'd15);

        // N=2 fixed matrices.
        ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
        mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
        mac_lat_max = 3;
        load_and_model(2, 32'd2, 1);
        do_start();
        wait_done("t2", 2000);
        check_run("t2", 2);
        check("t2_c_literal", {mem[12'h801], mem[12'h802], mem[12'h803], mem[12'h804]},
              {32'd19, 32'd22, 32'd43, 32'd50});

        // N=2 with op_ready low for 3 cycles on every pair.
        ready_mode = 1;
        gen_random(2, 0);
        load_and_model(2, ($urandom & 32'hFFFF_FFC0) | 32'd2, 1);
        do_start();
        wait_done("t3", 4000);
        check_run("t3", 2);

        // N=4, full-width random data, random ready, stray acc_valid pulses.
        ready_mode = 2; noise_en = 1'b1;
        gen_random(4, 1);
        load_and_model(4, ($urandom & 32'hFFFF_FFC0) | 32'd4, 1);
        do_start();
        wait_done("t4", 20000);
        check_run("t4", 4);
        ready_mode = 0; noise_en = 1'b0;

        // N=3 with a start pulse mid-run (must be ignored).
        gen_random(3, 0);
        load_and_model(3, 32'd3, 1);
        do_start();
        repeat (20) @(negedge clk);
        do_start();
        wait_done("t5", 8000);
        check_run("t5", 3);

        // Second run: result_ready held while idle, cleared by the new start.
        gen_random(3, 1);
        load_and_model(3, 32'd3, 1);
        check("t5b_rr_held", result_ready, 1);
        do_start();
        check("t5b_rr_cleared", result_ready, 0);
        wait_done("t5b", 8000);
        check_run("t5b", 3);

        // Illegal dimensions.
        foreach (err_words[e]) begin
            load_and_model(0, err_words[e], 0);
            do_start();
            check($sformatf("err%0d_cleared_on_start", e), {result_ready, error}, 0);
            cnt = 1;
            while (busy && cnt < 10) begin
                @(negedge clk);
                cnt++;
            end
            check($sformatf("err%0d_busy_low_fast", e), 64'(cnt <= 4), 1);
            @(negedge clk);
            check($sformatf("err%0d_flags", e), {busy, result_ready, error}, 3'b001);
            check($sformatf("err%0d_no_writes", e), wr_cnt, 0);
        end

        // Reset during WAIT_ACC of element (0,1).
        mac_lat_min = 8; mac_lat_max = 8;
        gen_random(2, 0);
        load_and_model(2, 32'd2, 1);
        do_start();
        check("rst_err_cleared", error, 0);
        cnt = 0;
        while (pair_cnt < 4 && cnt < 500) begin
            @(negedge clk);
            cnt++;
        end
        check("rst_reached_elem01", 64'(pair_cnt >= 4), 1);
        @(posedge clk);
        #3 reset = 1'b1;
        #1 check_outputs_zero("rst_mid");
        check("rst_c00_written", mem[12'h801], mc[0][0]);
        check("rst_c01_untouched", mem[12'h802], sentinel(1));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mac_lat_min = 0; mac_lat_max = 2;
        gen_random(2, 0);
        load_and_model(2, 32'd2, 0);
        do_start();
        wait_done("t7", 2000);
        check_run("t7", 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
